// File: rtl/alu_sched_pkg.sv
// Shared definitions for the ALU time-share scheduler: op codes, FSM encoding, op legality.
package alu_sched_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // Encodings the shared ALU does not implement.
  function automatic logic is_legal_op(input logic [2:0] op);
    return !(op == 3'b100 || op == 3'b110 || op == 3'b111);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr, wrapping mod NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_idx
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    gnt     = '0;
    gnt_idx = '0;
    // Walk from the farthest candidate back to ptr so the closest hit overwrites the others.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(ptr) + k) % NUM_REQ;
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        gnt_idx  = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/alu_share_sched.sv
// Round-robin scheduler time-sharing one ALU among NUM_REQ requesters with a tagged response.
// Optional `ALU_SCHED_OPCHECK_EN: illegal ops bypass the ALU and respond with rsp_err=1.
module alu_share_sched
  import alu_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int ID_W    = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [3*NUM_REQ-1:0]      req_op,
  input  logic [DATA_W*NUM_REQ-1:0] req_a,
  input  logic [DATA_W*NUM_REQ-1:0] req_b,
  output logic [DATA_W-1:0]         alu_src_a,
  output logic [DATA_W-1:0]         alu_src_b,
  output logic [2:0]                alu_control,
  input  logic [DATA_W-1:0]         alu_result,
  input  logic                      alu_zero,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_result,
  output logic                      rsp_zero,
  output logic                      rsp_err
);

  state_e              state, state_nxt;
  logic [ID_W-1:0]     rr_ptr;
  logic [NUM_REQ-1:0]  gnt;
  logic [ID_W-1:0]     gnt_idx;
  logic                accept;
  logic                sel_illegal;
  logic [2:0]          sel_op;
  logic [DATA_W-1:0]   sel_a, sel_b;

  logic [2:0]          op_q;
  logic [DATA_W-1:0]   a_q, b_q;
  logic [ID_W-1:0]     id_q;
  logic [DATA_W-1:0]   result_q;
  logic                zero_q;
  logic                err_q;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = (state == IDLE) ? gnt : '0;
  assign accept    = |(req_valid & req_ready);
  assign sel_op    = req_op[3*gnt_idx +: 3];
  assign sel_a     = req_a[gnt_idx*DATA_W +: DATA_W];
  assign sel_b     = req_b[gnt_idx*DATA_W +: DATA_W];

`ifdef ALU_SCHED_OPCHECK_EN
  assign sel_illegal = !is_legal_op(sel_op);
`else
  assign sel_illegal = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = sel_illegal ? RESP : EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    // NOTE: holding registers are reset too, because they drive the ALU and response ports directly.
    if (reset) begin
      rr_ptr   <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      id_q     <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        op_q   <= sel_op;
        a_q    <= sel_a;
        b_q    <= sel_b;
        id_q   <= gnt_idx;
        rr_ptr <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        // Illegal ops never visit EXEC, so their canned response is loaded at accept.
        if (sel_illegal) begin
          result_q <= '0;
          zero_q   <= 1'b1;
          err_q    <= 1'b1;
        end
      end
      if (state == EXEC) begin
        result_q <= alu_result;
        zero_q   <= alu_zero;
        err_q    <= 1'b0;
      end
    end
  end

  assign alu_src_a   = a_q;
  assign alu_src_b   = b_q;
  assign alu_control = op_q;
  assign rsp_valid   = (state == RESP);
  assign rsp_id      = id_q;
  assign rsp_result  = result_q;
  assign rsp_zero    = zero_q;
  assign rsp_err     = err_q;

endmodule

// File: tb/tb_alu_share_sched.sv
// Directed bench for alu_share_sched with a behavioural ALU; honours `ALU_SCHED_OPCHECK_EN.
module tb_alu_share_sched;
  import alu_sched_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 32;
  localparam int ID_W    = 2;

`ifdef ALU_SCHED_OPCHECK_EN
  localparam bit OPCHECK = 1'b1;
`else
  localparam bit OPCHECK = 1'b0;
`endif

  logic                      clk = 1'b0;
  logic                      reset = 1'b1;
  logic [NUM_REQ-1:0]        req_valid = '0;
  logic [NUM_REQ-1:0]        req_ready;
  logic [3*NUM_REQ-1:0]      req_op = '0;
  logic [DATA_W*NUM_REQ-1:0] req_a = '0;
  logic [DATA_W*NUM_REQ-1:0] req_b = '0;
  logic [DATA_W-1:0]         alu_src_a, alu_src_b, alu_result;
  logic [2:0]                alu_control;
  logic                      alu_zero;
  logic                      rsp_valid;
  logic                      rsp_ready = 1'b1;
  logic [ID_W-1:0]           rsp_id;
  logic [DATA_W-1:0]         rsp_result;
  logic                      rsp_zero, rsp_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_share_sched #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
  );

  // Reference ALU; undefined encodings produce 0.
  always_comb begin
    case (alu_control)
      ALU_ADD: alu_result = alu_src_a + alu_src_b;
      ALU_SUB: alu_result = alu_src_a - alu_src_b;
      ALU_AND: alu_result = alu_src_a & alu_src_b;
      ALU_OR:  alu_result = alu_src_a | alu_src_b;
      ALU_SLT: alu_result = ($signed(alu_src_a) < $signed(alu_src_b)) ? 32'd1 : 32'd0;
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    req_op[3*i +: 3]           = op;
    req_a[DATA_W*i +: DATA_W]  = a;
    req_b[DATA_W*i +: DATA_W]  = b;
  endtask

  // One request from requester i with the DUT idle and rsp_ready high.
  task automatic do_txn(input string name, input int i, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic exp_zero);
    logic illegal;
    logic [3:0] exp_rdy;
    illegal = OPCHECK && (op == 3'b100 || op == 3'b110 || op == 3'b111);
    exp_rdy = 4'(1 << i);
    set_req(i, op, a, b);
    req_valid[i] = 1'b1;
    #1;
    n_cmp++; if (req_ready !== exp_rdy) begin n_bad++; $display("FAIL %s ready: got %b want %b", name, req_ready, exp_rdy); end
    cyc();
    req_valid[i] = 1'b0;
    #1;
    if (!illegal) begin
      n_cmp++; if ({alu_control, alu_src_a, alu_src_b} !== {op, a, b}) begin n_bad++;
        $display("FAIL %s alu_in: got %h/%h/%h want %h/%h/%h", name, alu_control, alu_src_a, alu_src_b, op, a, b); end
      n_cmp++; if (rsp_valid !== 1'b0 || req_ready !== '0) begin n_bad++;
        $display("FAIL %s exec: rsp_valid=%b req_ready=%b want 0/0", name, rsp_valid, req_ready); end
      cyc();
      #1;
    end
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== ID_W'(i)) begin n_bad++;
      $display("FAIL %s rsp_hdr: valid=%b id=%0d want 1/%0d", name, rsp_valid, rsp_id, i); end
    n_cmp++; if ({rsp_result, rsp_zero, rsp_err} !== {exp_res, exp_zero, illegal}) begin n_bad++;
      $display("FAIL %s rsp_data: got res=%h z=%b e=%b want res=%h z=%b e=%b",
               name, rsp_result, rsp_zero, rsp_err, exp_res, exp_zero, illegal); end
    cyc();
    #1;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL %s rsp_drop: got %b want 0", name, rsp_valid); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc();
    cyc();
    #1;
    n_cmp++; if ({rsp_valid, req_ready, rsp_err, rsp_zero} !== 7'd0) begin n_bad++;
      $display("FAIL reset_flags: got %b want 0", {rsp_valid, req_ready, rsp_err, rsp_zero}); end
    n_cmp++; if ({alu_control, alu_src_a, alu_src_b, rsp_result, rsp_id} !== '0) begin n_bad++;
      $display("FAIL reset_data: got %h/%h/%h/%h/%h want 0", alu_control, alu_src_a, alu_src_b, rsp_result, rsp_id); end
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_single();
    do_txn("add_r0", 0, ALU_ADD, 32'd5, 32'd7, 32'd12, 1'b0);
  endtask

  task automatic test_ops();
    do_txn("sub_r2", 2, ALU_SUB, 32'h1234, 32'h1234, 32'd0, 1'b1);
    do_txn("slt_r1", 1, ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0);
    do_txn("or_r3",  3, ALU_OR,  32'hA000_0005, 32'h0000_0050, 32'hA000_0055, 1'b0);
  endtask

  task automatic test_round_robin();
    int g, seen, last_c;
    test_reset();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, ALU_ADD, 32'h10 * i + 1, i);
    req_valid = '1;
    g = 0; seen = 0; last_c = 0;
    #1;
    for (int c = 0; c < 40 && seen < 5; c++) begin
      if (req_ready !== '0) begin
        n_cmp++; if (req_ready !== 4'(1 << (g % 4)) || (g > 0 && c - last_c != 3)) begin n_bad++;
          $display("FAIL rr_grant%0d: got %b at gap %0d want %b at gap 3", g, req_ready, c - last_c, 4'(1 << (g % 4))); end
        last_c = c;
        g++;
      end
      if (rsp_valid === 1'b1) begin
        n_cmp++; if (rsp_id !== ID_W'(seen % 4) || rsp_result !== 32'(17 * (seen % 4) + 1)) begin n_bad++;
          $display("FAIL rr_rsp%0d: got id=%0d res=%0d want id=%0d res=%0d", seen, rsp_id, rsp_result,
                   seen % 4, 17 * (seen % 4) + 1); end
        seen++;
        if (seen == 5) req_valid = '0;
      end
      cyc();
      #1;
    end
    n_cmp++; if (seen != 5 || g != 5) begin n_bad++; $display("FAIL rr_count: got %0d rsp %0d grants want 5/5", seen, g); end
    req_valid = '0;
    cyc();
  endtask

  task automatic test_back_to_back();
    rsp_ready = 1'b0;
    set_req(3, ALU_AND, 32'hF0F0_FF00, 32'h0FF0_F0F0);
    req_valid[3] = 1'b1;
    cyc();
    req_valid[3] = 1'b0;
    cyc();
    set_req(1, ALU_OR, 32'd1, 32'd2);
    req_valid[1] = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      n_cmp++; if ({rsp_valid, rsp_id, rsp_result, req_ready} !== {1'b1, 2'd3, 32'h00F0_F000, 4'b0000}) begin n_bad++;
        $display("FAIL hold%0d: got v=%b id=%0d res=%h rdy=%b want 1/3/00f0f000/0000", k, rsp_valid, rsp_id, rsp_result, req_ready); end
      cyc();
      #1;
    end
    rsp_ready = 1'b1;
    cyc();
    #1;
    n_cmp++; if (req_ready !== 4'b0010 || rsp_valid !== 1'b0) begin n_bad++;
      $display("FAIL release: got rdy=%b v=%b want 0010/0", req_ready, rsp_valid); end
    cyc();
    req_valid[1] = 1'b0;
    cyc();
    #1;
    n_cmp++; if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 2'd1, 32'd3}) begin n_bad++;
      $display("FAIL b2b_rsp: got v=%b id=%0d res=%h want 1/1/3", rsp_valid, rsp_id, rsp_result); end
    cyc();
  endtask

  task automatic test_reset_exec();
    set_req(1, ALU_ADD, 32'd40, 32'd2);
    req_valid[1] = 1'b1;
    cyc();
    req_valid[1] = 1'b0;
    #1;
    n_cmp++; if (alu_src_a !== 32'd40) begin n_bad++; $display("FAIL pre_reset_exec: got %h want 28", alu_src_a); end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
    n_cmp++; if ({rsp_valid, alu_control, alu_src_a, rsp_result} !== '0) begin n_bad++;
      $display("FAIL post_reset: got v=%b op=%h a=%h res=%h want 0", rsp_valid, alu_control, alu_src_a, rsp_result); end
    for (int k = 0; k < 4; k++) begin
      cyc();
      #1;
      n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL ghost_rsp%0d: got %b want 0", k, rsp_valid); end
    end
    req_valid = '1;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL ptr_reset: got %b want 0001", req_ready); end
    req_valid = '0;
    cyc();
  endtask

  task automatic test_opcheck();
    do_txn("op111", 0, 3'b111, 32'd9, 32'd3, 32'd0, 1'b1);
    do_txn("op100", 2, 3'b100, 32'd6, 32'd6, 32'd0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_ops();
    test_round_robin();
    test_back_to_back();
    test_reset_exec();
    test_opcheck();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
